// File: rtl/fpadd_norm.sv
// fpadd_norm: post-addition normalizer for the floating-point adder.
// Three-stage valid/ready pipeline: leading-zero count, barrel shift,
// exponent adjust and flags. Optional feature macro: FPADD_NORM_STICKY_EN
// (defined: sticky computed and carried in fR[0]; undefined: fR[0] tied 0).
module fpadd_norm #(
    parameter int wE = 4,
    parameter int wF = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [wF+4:0] mS,
    input  logic [wE-1:0] eS,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [wF+1:0] fR,
    output logic [wE-1:0] eR,
    output logic          zero,
    output logic          ovf,
    output logic          unf
);

    localparam int MW = wF + 5;            // significand width incl. carry
    localparam int ZW = $clog2(MW);        // leading-zero count width
    localparam int CW = (wE > ZW) ? wE : ZW;
    localparam logic [wE-1:0] E_OVF = {{(wE-1){1'b1}}, 1'b0};

    // One global advance: every stage moves together or holds together.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Leading zeros of the hidden-and-below field; MW-1 when the field is zero.
    function automatic logic [ZW-1:0] lzc(input logic [MW-2:0] v);
        logic [ZW-1:0] n;
        n = ZW'(MW - 1);
        for (int i = 0; i < MW - 1; i++)
            if (v[i]) n = ZW'(MW - 2 - i);
        return n;
    endfunction

    // ---------------- Stage 1: capture, classify, count zeros ----------------
    logic          s1_valid;
    logic [MW-1:0] s1_m;
    logic [wE-1:0] s1_e;
    logic          s1_carry;
    logic          s1_allz;
    logic [ZW-1:0] s1_z;

    // Stage-1 valid bit, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all stages
        // sample the previous cycle's values regardless of block ordering.
        if (rst)      s1_valid <= 1'b0;
        else if (adv) s1_valid <= in_valid;
    end

    // Stage-1 data capture on advance.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; a bubble's stale data is
        // masked by its valid bit and never reaches the rounder.
        if (adv) begin
            s1_m     <= mS;
            s1_e     <= eS;
            s1_carry <= mS[MW-1];
            s1_allz  <= (mS == '0);
            s1_z     <= lzc(mS[MW-2:0]);
        end
    end

    // ---------------- Stage 2: normalizing barrel shift ----------------
    logic [MW-1:0] sh;
    logic          lost;
    logic          sticky;
    logic          unused_bits;

    // Right shift by one on carry-out, otherwise log-stage left shift by z.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        sh   = s1_m;
        lost = 1'b0;
        if (s1_carry) begin
            sh   = s1_m >> 1;
            lost = s1_m[0];
        end else begin
            for (int k = 0; k < ZW; k++)
                if (s1_z[k]) sh = sh << (2 ** k);
        end
    end

`ifdef FPADD_NORM_STICKY_EN
    assign sticky      = (|sh[1:0]) | lost;
    assign unused_bits = ^sh[MW-1:MW-2];
`else
    assign sticky      = 1'b0;
    assign unused_bits = ^{sh[MW-1:MW-2], sh[1:0], lost};
`endif

    logic          s2_valid;
    logic [wF-1:0] s2_frac;
    logic          s2_guard;
    logic          s2_sticky;
    logic          s2_carry;
    logic          s2_allz;
    logic [ZW-1:0] s2_z;
    logic [wE-1:0] s2_e;

    // Stage-2 valid bit, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)      s2_valid <= 1'b0;
        else if (adv) s2_valid <= s1_valid;
    end

    // Stage-2 data capture on advance.
    always_ff @(posedge clk) begin
        if (adv) begin
            s2_frac   <= sh[wF+2:3];
            s2_guard  <= sh[2];
            s2_sticky <= sticky;
            s2_carry  <= s1_carry;
            s2_allz   <= s1_allz;
            s2_z      <= s1_z;
            s2_e      <= s1_e;
        end
    end

    // ---------------- Stage 3: exponent adjust and flags ----------------
    logic          n_zero, n_unf, n_ovf;
    logic [wE-1:0] n_e;
    logic [wF+1:0] n_f;

    // Flag priority zero > unf > ovf > normal; flagged results carry fR=0.
    always_comb begin
        n_zero = 1'b0;
        n_unf  = 1'b0;
        n_ovf  = 1'b0;
        n_e    = '0;
        n_f    = '0;
        if (s2_allz) begin
            n_zero = 1'b1;
        end else if (!s2_carry && (CW'(s2_z) >= CW'(s2_e))) begin
            n_unf = 1'b1;
        end else if (s2_carry && (s2_e == E_OVF)) begin
            n_ovf = 1'b1;
            n_e   = '1;
        end else begin
            n_f = {s2_frac, s2_guard, s2_sticky};
            n_e = s2_carry ? (s2_e + wE'(1)) : (s2_e - wE'(s2_z));
        end
    end

    // Output register: valid on every advance, data only for real beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            fR        <= '0;
            eR        <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                zero <= n_zero;
                ovf  <= n_ovf;
                unf  <= n_unf;
                fR   <= n_f;
                eR   <= n_e;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_norm.sv
// Self-checking bench for fpadd_norm (wE=4, wF=5). Expected results come from
// an arithmetic model: normalize by the position of the leading one.
module tb_fpadd_norm;

    localparam int WE = 4;
    localparam int WF = 5;
    localparam int MW = WF + 5;
`ifdef FPADD_NORM_STICKY_EN
    localparam logic ST = 1'b1;
`else
    localparam logic ST = 1'b0;
`endif

    typedef struct packed {
        logic          zero;
        logic          unf;
        logic          ovf;
        logic [WE-1:0] e;
        logic [WF+1:0] f;
    } res_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic          zero, ovf, unf;
    logic [MW-1:0] mS;
    logic [WE-1:0] eS;
    logic [WF+1:0] fR;
    logic [WE-1:0] eR;

    int n_vec = 0;
    int n_err = 0;

    res_t          exp_q[$];
    logic [MW-1:0] stim_m[$];
    logic [WE-1:0] stim_e[$];
    logic          hold_chk = 1'b0;
    logic [14:0]   saved;
    logic          saw_stall;

    fpadd_norm #(.wE(WE), .wF(WF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mS(mS), .eS(eS),
        .out_valid(out_valid), .out_ready(out_ready),
        .fR(fR), .eR(eR), .zero(zero), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value view: the leading one at position p sets the exponent shift (p-8);
    // the normalized integer exposes fraction, guard and the sticky remainder.
    function automatic res_t model(input int m, input int e);
        res_t r;
        int   p, n, lost, ez, frac, guard, st;
        r = '0;
        if (m == 0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < MW; i++)
            if (m >= (1 << i)) p = i;
        if (p > WF + 3) begin
            n    = m >> (p - (WF + 3));
            lost = m % (1 << (p - (WF + 3)));
        end else begin
            n    = m << ((WF + 3) - p);
            lost = 0;
        end
        ez = e + p - (WF + 3);
        if (ez <= 0) begin
            r.unf = 1'b1;
            return r;
        end
        if (p > WF + 3 && e == (1 << WE) - 2) begin
            r.ovf = 1'b1;
            r.e   = '1;
            return r;
        end
        frac  = (n >> 3) % (1 << WF);
        guard = (n >> 2) % 2;
        st    = ((n % 4) != 0 || lost != 0) ? 1 : 0;
        if (!ST) st = 0;
        r.e = WE'(ez % (1 << WE));
        r.f = (WF + 2)'(frac * 4 + guard * 2 + st);
        return r;
    endfunction

    // One clock: checks hold/retire, updates the scoreboard, crosses an edge.
    task automatic tick();
        logic acc, ret;
        res_t got;
        #1;
        if (!in_ready) saw_stall = 1'b1;
        acc = in_valid && in_ready && !rst;
        ret = out_valid && out_ready && !rst;
        if (hold_chk) check("hold_stable", {out_valid, fR, eR, zero, unf, ovf}, saved);
        hold_chk = out_valid && !out_ready && !rst;
        saved    = {out_valid, fR, eR, zero, unf, ovf};
        if (ret) begin
            got = {zero, unf, ovf, eR, fR};
            if (exp_q.size() == 0) check("spurious_output", out_valid, 0);
            else check("result", got, exp_q.pop_front());
        end
        if (rst) exp_q.delete();
        else if (acc) exp_q.push_back(model(mS, eS));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one beat into an idle pipe, check latency and the literal result.
    task automatic single(input string tag, input logic [MW-1:0] m, input logic [WE-1:0] e,
                          input res_t want);
        mS = m; eS = e; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_lat2"}, out_valid, 0);
        tick();
        check({tag, "_lat3"}, out_valid, 1);
        check(tag, {zero, unf, ovf, eR, fR}, want);
        tick();
    endtask

    // Drain the stimulus queue; mode 0 ready, 1 stall cycles 4-7, 2 random.
    task automatic run(input int mode);
        int  c = 0;
        logic acc;
        while ((stim_m.size() > 0 || exp_q.size() > 0 || in_valid) && c < 2000) begin
            if (!in_valid && stim_m.size() > 0) begin
                mS = stim_m.pop_front();
                eS = stim_e.pop_front();
                in_valid = 1'b1;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(c >= 4 && c <= 7);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            c++;
        end
        check("drain", exp_q.size() + stim_m.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mS = '0; eS = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fR", fR, 0);
        check("rst_eR", eR, 0);
        check("rst_flags", {zero, unf, ovf}, 0);

        single("normalized", 10'b01_0110_1000, 4'd7,  {3'b000, 4'd7,  7'b01101_0_0});
        single("carry",      10'b11_0000_0011, 4'd7,  {3'b000, 4'd8,  {5'b10000, 1'b0, ST}});
        single("cancel",     10'b00_0001_0100, 4'd9,  {3'b000, 4'd5,  7'b01000_0_0});
        single("underflow",  10'b00_0000_0001, 4'd3,  {3'b010, 4'd0,  7'b0});
        single("zero",       10'b00_0000_0000, 4'd9,  {3'b100, 4'd0,  7'b0});
        single("overflow",   10'b10_0000_0000, 4'd14, {3'b001, 4'd15, 7'b0});

        // Backpressure: six distinct beats, downstream stalls cycles 4-7.
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stim_m.push_back(MW'(($urandom & 32'h3F0) | 32'(i + 1)));
            stim_e.push_back(WE'($urandom_range(0, 15)));
        end
        run(1);
        check("stall_seen", saw_stall, 1);

        // Reset with three beats in flight: none may ever emerge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mS = MW'($urandom_range(1, 1023)); eS = WE'($urandom_range(1, 15));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        repeat (6) tick();
        check("rst_mid_quiet", out_valid, 0);

        // Random traffic with random backpressure; small magnitudes favoured.
        for (int i = 0; i < 300; i++) begin
            stim_m.push_back(MW'($urandom_range(0, 1023) >> $urandom_range(0, 9)));
            stim_e.push_back(WE'($urandom_range(0, 15)));
        end
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpadd_norm.md
# fpadd_norm

Post-addition normalizer for the floating-point adder datapath. Takes the unsigned significand magnitude from the mantissa adder and the pre-normalization exponent, and produces a normalized result. Carry-out is handled by a right shift of 1; cancellation by a leading-zero count and a left shift. The exponent is adjusted to match, and the block emits fraction, guard and sticky bits for the rounding stage. Three-stage valid/ready pipeline, sitting between the adder and the rounder, on the opposite side of the adder from the alignment right-shifter.

## Interface
- wE, 4, exponent width (biased, unsigned)
- wF, 5, fraction width (hidden bit excluded)
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- mS  input  wF+5  significand magnitude
  - bit wF+4 = carry (weight 2)
  - bit wF+3 = hidden (weight 1)
  - bits wF+2..0 = fraction and lower bits
- eS  input  wE  pre-normalization exponent
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- fR  output  wF+2  normalized result {fraction[wF-1:0], guard, sticky}, hidden bit dropped
- eR  output  wE  adjusted exponent
- zero  output  1  result is exact zero
- ovf  output  1  exponent overflow, result is infinity encoding
- unf  output  1  exponent underflow, result flushed to zero

## Operation
- Stage 1 (S1): register mS and eS.
  - Compute carry = mS[wF+4].
  - Compute z = leading-zero count of mS[wF+3:0], width ceil(log2(wF+5)).
  - Compute allz = (mS == 0).
- Stage 2 (S2): barrel shift, log2 stages, combinational within the cycle.
  - carry=1: right shift by 1. Bits shifted out OR into sticky.
  - carry=0: left shift by z, zero fill.
  - Fraction = shifted bits [wF+2:3]; guard = shifted bit [2].
  - Sticky = OR of shifted bits [1:0], ORed with any bit lost by the right shift.
- Stage 3 (S3): exponent adjust and flags. Priority is zero > unf > ovf > normal.
  - allz: zero=1, eR=0, fR=0.
  - carry=0 and z ≥ eS: unf=1, eR=0, fR=0. No subnormals.
  - carry=1 and eS == 2^wE-2: ovf=1, eR=all ones, fR=0.
  - carry=1 otherwise: eR = eS+1.
  - carry=0 otherwise: eR = eS−z.
- Exactly one of {zero, unf, ovf} or none is set per result. Flags are valid only with out_valid.

## Timing
- Latency is 3 cycles from accepted beat (in_valid & in_ready) to out_valid. Throughput is 1 beat/cycle when not stalled.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational.
- When adv=0, all stage registers and valid bits hold. No beat is dropped or duplicated, and order is preserved.
- Bubbles propagate as valid=0. Data registers need not clear on bubbles.
- Simultaneous in_valid and out_ready while full: output retires and new beat enters in the same cycle.
- Reset:
  - Stage valids, out_valid, zero, ovf and unf go to 0.
  - fR=0 and eR=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats. No output for them after reset.
- out_valid must not depend combinationally on out_ready.

## Configuration
- FPADD_NORM_STICKY_EN defined:
  - Sticky computed as in S2.
  - fR[0] carries the sticky bit.
- FPADD_NORM_STICKY_EN undefined:
  - Sticky logic is removed and fR[0] is tied 0.
  - All other bits, flags and timing are identical.

## Test plan
All scenarios use wE=4, wF=5 with FPADD_NORM_STICKY_EN defined unless stated.
- Already normalized: mS=10'b01_0110_1000, eS=7 → fR=7'b01101_0_0, eR=7, no flags, out_valid 3 cycles after accept.
- Carry-out: mS=10'b11_0000_0011, eS=7 → fR=7'b10000_0_1, eR=8.
  - With macro undefined: fR=7'b10000_0_0.
- Cancellation: mS=10'b00_0001_0100, eS=9 → z=4, fR=7'b01000_0_0, eR=5.
- Underflow/zero/overflow:
  - mS=10'b00_0000_0001, eS=3 → unf=1, eR=0, fR=0.
  - mS=0, eS=9 → zero=1, eR=0.
  - mS=10'b10_0000_0000, eS=14 → ovf=1, eR=15, fR=0.
- Backpressure: stream 6 distinct beats with out_ready held 0 for cycles 4–7.
  - in_ready drops while stalled.
  - All 6 results emerge in order with none lost or repeated.
  - Outputs hold stable while out_valid & !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight.
  - out_valid=0 the next cycle.
  - None of the 3 beats ever appears at the output.
